// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths, request record and round-robin pointer helper for the write-back mux
package wb_pkg;

  localparam int DATA_W  = 64;
  localparam int REG_AW  = 5;
  localparam int XZR_IDX = 31;
  localparam int IDX_W   = 3;  // wide enough for up to 8 sources

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] ptr,
                                               input logic [IDX_W-1:0] winner,
                                               input logic             adv,
                                               input int               num_req);
    if (!adv) return ptr;
    if (int'(winner) == num_req - 1) return '0;
    return winner + 1'b1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin request arbiter; WB_FIXED_PRIO_EN selects fixed lowest-index priority
module rr_arbiter
  import wb_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   winner
);

`ifdef WB_FIXED_PRIO_EN

  // Scan from the top so the lowest valid index is the last one written.
  always_comb begin
    grant  = '0;
    winner = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        winner   = IDX_W'(j);
      end
    end
  end

`else

  logic [IDX_W-1:0] rr_ptr_q;
  logic             found;

  // First pass covers indices at or above the pointer, second pass the wrapped remainder.
  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && req[j] && (j >= int'(rr_ptr_q))) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        winner   = IDX_W'(j);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        winner   = IDX_W'(j);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_next(rr_ptr_q, winner, advance, NUM_REQ);
    end
  end

`endif

endmodule

// File: rtl/wb_arbiter_mux.sv
// rtl/wb_arbiter_mux.sv - NUM_SRC-way write-back arbiter feeding one registered register-file port
// Optional fixed-priority arbitration via WB_FIXED_PRIO_EN.
module wb_arbiter_mux #(
  parameter int DATA_W  = wb_pkg::DATA_W,
  parameter int NUM_SRC = 3,
  parameter int REG_AW  = wb_pkg::REG_AW,
  parameter int XZR_IDX = wb_pkg::XZR_IDX
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC*REG_AW-1:0] src_rd,
  input  logic                      wb_stall,
  output logic                      rf_we,
  output logic [REG_AW-1:0]         rf_waddr,
  output logic [DATA_W-1:0]         rf_wdata,
  output logic                      busy
);

  logic [NUM_SRC-1:0]        grant;
  logic [wb_pkg::IDX_W-1:0]  winner;
  logic                      accept;
  logic [REG_AW-1:0]         sel_rd;
  logic [DATA_W-1:0]         sel_data;

  logic                      rf_we_d, rf_we_q;
  logic [REG_AW-1:0]         rf_waddr_d, rf_waddr_q;
  logic [DATA_W-1:0]         rf_wdata_d, rf_wdata_q;

  rr_arbiter #(.NUM_REQ(NUM_SRC)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (src_valid),
    .advance (accept),
    .grant   (grant),
    .winner  (winner)
  );

  // Grants are masked during reset too, so no source sees a handshake while rst_n is low.
  assign src_ready = grant & {NUM_SRC{rst_n & ~wb_stall}};
  assign accept    = |src_ready;

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (winner == wb_pkg::IDX_W'(i)) begin
        sel_rd   = src_rd[i*REG_AW +: REG_AW];
        sel_data = src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    rf_we_d    = rf_we_q;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (!wb_stall) begin
      if (accept) begin
        rf_waddr_d = sel_rd;
        rf_wdata_d = sel_data;
        rf_we_d    = (sel_rd != REG_AW'(XZR_IDX));
      end else begin
        rf_we_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign busy     = (|src_valid) | rf_we_q;

endmodule

// File: tb/tb_wb_arbiter_mux.sv
// tb/tb_wb_arbiter_mux.sv - table-driven self-checking bench for wb_arbiter_mux
module tb_wb_arbiter_mux;

  localparam int NS = 3;

  logic            clk;
  logic            rst_n;
  logic [NS-1:0]   src_valid;
  logic [NS-1:0]   src_ready;
  logic [NS*64-1:0] src_data;
  logic [NS*5-1:0] src_rd;
  logic            wb_stall;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [63:0]     rf_wdata;
  logic            busy;

  int errors = 0;
  int checks = 0;

  wb_arbiter_mux #(.DATA_W(64), .NUM_SRC(NS), .REG_AW(5), .XZR_IDX(31)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .src_data  (src_data),
    .src_rd    (src_rd),
    .wb_stall  (wb_stall),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   valid;
    logic [14:0]  rd;
    logic [191:0] data;
    logic         stall;
    logic [2:0]   ready;
    logic         we;
    logic [4:0]   waddr;
    logic [63:0]  wdata;
  } vec_t;

  localparam logic [63:0] A0 = 64'hA0A0, A1 = 64'hA1A1, A2 = 64'hA2A2;
  localparam logic [63:0] B1 = 64'hB1B1, C0 = 64'hC0C0, C1 = 64'hC1C1;
  localparam logic [63:0] D0 = 64'hD0D0, D1 = 64'hD1D1, DB = 64'hDEAD_BEEF;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] valid, input logic [14:0] rd, input logic [191:0] data,
                              input logic stall, input logic [2:0] ready, input logic we,
                              input logic [4:0] waddr, input logic [63:0] wdata);
    vec_t v;
    v.valid = valid; v.rd = rd; v.data = data; v.stall = stall;
    v.ready = ready; v.we = we; v.waddr = waddr; v.wdata = wdata;
    return v;
  endfunction

  vec_t tbl[29];

  initial begin
    logic [14:0]  rd_rr;
    logic [191:0] dt_rr;
    rd_rr = {5'd3, 5'd2, 5'd1};
    dt_rr = {A2, A1, A0};

    tbl[0]  = mk(3'b111, rd_rr, dt_rr, 1'b0, 3'b001, 1'b0, 5'd0, 64'd0);
    tbl[1]  = mk(3'b111, rd_rr, dt_rr, 1'b0, 3'b010, 1'b1, 5'd1, A0);
    tbl[2]  = mk(3'b111, rd_rr, dt_rr, 1'b0, 3'b100, 1'b1, 5'd2, A1);
    tbl[3]  = mk(3'b111, rd_rr, dt_rr, 1'b0, 3'b001, 1'b1, 5'd3, A2);
    tbl[4]  = mk(3'b111, rd_rr, dt_rr, 1'b0, 3'b010, 1'b1, 5'd1, A0);
    tbl[5]  = mk(3'b111, rd_rr, dt_rr, 1'b0, 3'b100, 1'b1, 5'd2, A1);
    tbl[6]  = mk(3'b000, 15'd0, 192'd0, 1'b0, 3'b000, 1'b1, 5'd3, A2);
    tbl[7]  = mk(3'b001, 15'd5, {128'd0, DB}, 1'b0, 3'b001, 1'b0, 5'd3, A2);
    tbl[8]  = mk(3'b000, 15'd0, 192'd0, 1'b0, 3'b000, 1'b1, 5'd5, DB);
    tbl[9]  = mk(3'b000, 15'd0, 192'd0, 1'b0, 3'b000, 1'b0, 5'd5, DB);
    tbl[10] = mk(3'b010, {5'd0, 5'd9, 5'd0}, {64'd0, B1, 64'd0}, 1'b1, 3'b000, 1'b0, 5'd5, DB);
    tbl[11] = mk(3'b010, {5'd0, 5'd9, 5'd0}, {64'd0, B1, 64'd0}, 1'b1, 3'b000, 1'b0, 5'd5, DB);
    tbl[12] = mk(3'b010, {5'd0, 5'd9, 5'd0}, {64'd0, B1, 64'd0}, 1'b1, 3'b000, 1'b0, 5'd5, DB);
    tbl[13] = mk(3'b010, {5'd0, 5'd9, 5'd0}, {64'd0, B1, 64'd0}, 1'b0, 3'b010, 1'b0, 5'd5, DB);
    tbl[14] = mk(3'b000, 15'd0, 192'd0, 1'b0, 3'b000, 1'b1, 5'd9, B1);
    tbl[15] = mk(3'b100, {5'd31, 10'd0}, {64'd7, 128'd0}, 1'b0, 3'b100, 1'b0, 5'd9, B1);
    tbl[16] = mk(3'b100, {5'd4, 10'd0}, {64'd8, 128'd0}, 1'b0, 3'b100, 1'b0, 5'd31, 64'd7);
    tbl[17] = mk(3'b000, 15'd0, 192'd0, 1'b0, 3'b000, 1'b1, 5'd4, 64'd8);
    tbl[18] = mk(3'b000, 15'd0, 192'd0, 1'b0, 3'b000, 1'b0, 5'd4, 64'd8);
    tbl[19] = mk(3'b001, 15'd6, {128'd0, C0}, 1'b0, 3'b001, 1'b0, 5'd4, 64'd8);
    tbl[20] = mk(3'b010, {5'd0, 5'd7, 5'd0}, {64'd0, C1, 64'd0}, 1'b1, 3'b000, 1'b1, 5'd6, C0);
    tbl[21] = mk(3'b010, {5'd0, 5'd7, 5'd0}, {64'd0, C1, 64'd0}, 1'b1, 3'b000, 1'b1, 5'd6, C0);
    tbl[22] = mk(3'b010, {5'd0, 5'd7, 5'd0}, {64'd0, C1, 64'd0}, 1'b0, 3'b010, 1'b1, 5'd6, C0);
    tbl[23] = mk(3'b000, 15'd0, 192'd0, 1'b0, 3'b000, 1'b1, 5'd7, C1);
    tbl[24] = mk(3'b000, 15'd0, 192'd0, 1'b0, 3'b000, 1'b0, 5'd7, C1);
    tbl[25] = mk(3'b011, {5'd0, 5'd11, 5'd10}, {64'd0, D1, D0}, 1'b0, 3'b001, 1'b0, 5'd7, C1);
    tbl[26] = mk(3'b011, {5'd0, 5'd11, 5'd10}, {64'd0, D1, D0}, 1'b0, 3'b010, 1'b1, 5'd10, D0);
    tbl[27] = mk(3'b000, 15'd0, 192'd0, 1'b0, 3'b000, 1'b1, 5'd11, D1);
    tbl[28] = mk(3'b000, 15'd0, 192'd0, 1'b0, 3'b000, 1'b0, 5'd11, D1);

    rst_n = 1'b0; src_valid = '0; src_rd = '0; src_data = '0; wb_stall = 1'b0;
    #1;
    chk("reset_we",    64'(rf_we),     64'd0);
    chk("reset_waddr", 64'(rf_waddr),  64'd0);
    chk("reset_wdata", rf_wdata,       64'd0);
    chk("reset_ready", 64'(src_ready), 64'd0);
    chk("reset_busy",  64'(busy),      64'd0);
    @(negedge clk);
    rst_n = 1'b1;

`ifndef WB_FIXED_PRIO_EN
    for (int r = 0; r < 29; r++) begin
      @(negedge clk);
      src_valid = tbl[r].valid;
      src_rd    = tbl[r].rd;
      src_data  = tbl[r].data;
      wb_stall  = tbl[r].stall;
      #1;
      chk($sformatf("row%0d_ready", r), 64'(src_ready), 64'(tbl[r].ready));
      chk($sformatf("row%0d_we", r),    64'(rf_we),     64'(tbl[r].we));
      chk($sformatf("row%0d_waddr", r), 64'(rf_waddr),  64'(tbl[r].waddr));
      chk($sformatf("row%0d_wdata", r), rf_wdata,       tbl[r].wdata);
      chk($sformatf("row%0d_busy", r),  64'(busy),      64'((|tbl[r].valid) | tbl[r].we));
    end
`else
    @(negedge clk);
    src_valid = 3'b011;
    src_rd    = {5'd0, 5'd2, 5'd1};
    src_data  = {64'd0, A1, A0};
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("fixed%0d_ready", c), 64'(src_ready), 64'(3'b001));
      if (c > 0) chk($sformatf("fixed%0d_waddr", c), 64'(rf_waddr), 64'd1);
      @(negedge clk);
    end
`endif

    // Reset landing on a loaded output register clears it without a clock edge.
    @(negedge clk);
    wb_stall  = 1'b0;
    src_valid = 3'b001;
    src_rd    = 15'd12;
    src_data  = {128'd0, 64'h55};
    @(posedge clk);
    #1;
    chk("pre_rst_we",    64'(rf_we),    64'd1);
    chk("pre_rst_waddr", 64'(rf_waddr), 64'd12);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we",    64'(rf_we),     64'd0);
    chk("mid_rst_waddr", 64'(rf_waddr),  64'd0);
    chk("mid_rst_wdata", rf_wdata,       64'd0);
    chk("mid_rst_ready", 64'(src_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    src_valid = '0;
    #1;
    chk("post_rst_we", 64'(rf_we), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_arbiter_mux.md
Name: wb_arbiter_mux

Overview:
- Parametrised successor to the 2:1 write-back select in front of the register file.
- Accepts results from NUM_SRC producers (ALU, load unit, multiplier, ...) over valid/ready and arbitrates one winner per cycle.
- Registers the winner into a single register-file write port; one cycle of latency.
- Honours a stall input from downstream and suppresses writes to XZR (X31).

Parameters:
- DATA_W, 64, write-back data width in bits.
- NUM_SRC, 3, number of producer channels (2..8).
- REG_AW, 5, register address width.
- XZR_IDX, 31, zero-register index; writes to it are discarded.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- src_valid  in  NUM_SRC  per-source request valid.
- src_ready  out  NUM_SRC  per-source grant; combinational, one-hot or zero.
- src_data  in  NUM_SRC*DATA_W  per-source result; source i occupies bits [i*DATA_W +: DATA_W].
- src_rd  in  NUM_SRC*REG_AW  per-source destination register; same packing as src_data.
- wb_stall  in  1  downstream cannot take a write this cycle.
- rf_we  out  1  register-file write enable (registered).
- rf_waddr  out  REG_AW  register-file write address (registered).
- rf_wdata  out  DATA_W  register-file write data (registered).
- busy  out  1  high while any src_valid is high or rf_we is high.

Behaviour:
- Reset: asynchronous on rst_n low; rf_we=0, rf_waddr=0, rf_wdata=0, rr_ptr=0, all src_ready=0.
- Handshake: transfer on src_i when src_valid[i] && src_ready[i] in the same cycle. Sources hold valid, data and rd stable until accepted. Valid never depends on ready.
- Arbitration: round-robin starting at rr_ptr. Winner is the first valid index at or above rr_ptr, wrapping modulo NUM_SRC.
- After an accept, rr_ptr <= winner+1; it wraps to 0 when winner = NUM_SRC-1. rr_ptr is unchanged when nothing is accepted.
- Stall: when wb_stall=1, all src_ready=0 and the output registers hold their values; rf_we keeps its value.
- Output stage: on an accept and no stall, next edge loads rf_waddr=src_rd[w], rf_wdata=src_data[w], and rf_we=1 unless src_rd[w]==XZR_IDX.
  - A write to XZR_IDX is still accepted (ready pulses) but sets rf_we=0.
- With no accept and no stall, next edge sets rf_we=0; rf_waddr and rf_wdata hold.
- Latency: accept in cycle N gives the write in cycle N+1. Throughput is one write per cycle.
- Same rd from several sources in one cycle: serialised in grant order; the last-granted value persists in the register file.
- Reset asserted mid-transfer: the pending write is dropped, and sources must re-present after reset.
- No valid sources: no grant, and rr_ptr holds.

Optional Feature:
- Macro: WB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins (source 0 highest); rr_ptr is removed; a continuously valid source 0 may starve the others.
- Undefined: round-robin as above, where every continuously valid source is granted within NUM_SRC accepts.

Decomposition:
- Package wb_pkg:
  - DATA_W, REG_AW, XZR_IDX localparams.
  - typedef wb_req_t {logic [REG_AW-1:0] rd; logic [DATA_W-1:0] data;}.
  - function rr_next(ptr, winner).
- Sub-module rr_arbiter (NUM_REQ parameter):
  - Inputs req and advance; outputs one-hot grant and winner index.
  - Owns rr_ptr; the WB_FIXED_PRIO_EN switch lives inside it.
- The top level holds the output registers, stall gating and XZR suppression.

Test Plan:
- Reset: drive rst_n=0 mid-cycle -> rf_we=0, rf_waddr=0, rf_wdata=0, src_ready=0 immediately, with no clock edge needed.
- Single source: src_valid=3'b001, rd=5, data=64'hDEAD_BEEF -> src_ready=001 same cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=64'hDEAD_BEEF; cycle after, rf_we=0.
- Round-robin: src_valid=3'b111 held for 6 cycles with distinct rd 1/2/3 -> grants 0,1,2,0,1,2; rf_waddr sequence 1,2,3,1,2,3 one cycle later.
- Stall: wb_stall=1 for 3 cycles while src_valid=3'b010 -> src_ready=0 and outputs frozen; on release, grant source 1 and write next cycle.
- XZR: src_valid=3'b100, rd=31, data=7 -> src_ready[2]=1, next cycle rf_we=0; then rd=4 -> rf_we=1, rf_waddr=4.
- Fixed priority (WB_FIXED_PRIO_EN defined): src_valid=3'b011 for 4 cycles -> source 0 granted every cycle, source 1 never.
